flex_sipo_framer: RTL and testbench
===================================

# flex_sipo_framer

Parametrised serial-to-parallel framer: shifts serial bits in on `shift_enable`, counts them, and on every NUM_BITS-th bit transfers the completed word into a holding register, then flags it valid for a downstream consumer. It adds a live bit counter, a frame-done pulse, a valid/read handshake with overrun detection, and a synchronous frame abort. It sits between a bit-sampling front end (e.g. receiver timer/FSM) and the word-level consumer (e.g. receive buffer or status register).

## Interface
- NUM_BITS, 8, frame width in bits; legal range 2..32
- SHIFT_MSB, 1, 1: new bit enters at LSB and data moves toward MSB (MSB-first stream); 0: new bit enters at MSB and data moves toward LSB (LSB-first stream)
- FILL_BIT, 1, value loaded into every shift-register and holding-register bit on reset and on `clear`

- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- shift_enable  in  1  shift `serial_in` into the shift register this cycle
- serial_in  in  1  serial data bit
- clear  in  1  synchronous abort of the partial frame
- data_read  in  1  consumer acknowledges/consumes the holding register
- shift_out  out  NUM_BITS  live shift-register contents
- parallel_out  out  NUM_BITS  holding register (last completed frame)
- bit_count  out  $clog2(NUM_BITS+1)  bits received in the current partial frame
- data_valid  out  1  holding register holds an unread frame
- frame_done  out  1  one-cycle pulse: a frame completed on the previous edge
- overrun  out  1  sticky: a frame completed while the previous one was unread

## Operation
- Reset (async, rst=1): shift_out and parallel_out = all FILL_BIT; bit_count=0; data_valid=0; frame_done=0; overrun=0.
- Shift: when shift_enable=1 and clear=0, shift_out updates per SHIFT_MSB (MSB mode: {shift_out[N-2:0], serial_in}; LSB mode: {serial_in, shift_out[N-1:1]}); bit_count increments.
- Completion: shift accepted with bit_count==NUM_BITS-1. On that edge: parallel_out ← new shift value (including the current bit); bit_count ← 0; frame_done ← 1; data_valid ← 1. shift_out keeps the completed word (no refill).
- frame_done is 1 only for the cycle after a completion; otherwise 0.
- data_read with no completion in the same cycle: data_valid ← 0, overrun ← 0. data_read while data_valid=0 is harmless.
- Completion + data_read in the same cycle: new frame loaded, data_valid stays 1, overrun ← 0.
- Completion while data_valid=1 and data_read=0: parallel_out overwritten by the new frame, overrun ← 1. overrun holds until a data_read.
- clear=1: shift_out ← all FILL_BIT, bit_count ← 0. clear has priority over shift_enable, so a bit presented with clear is dropped and no completion occurs. parallel_out, data_valid and overrun are unaffected, and data_read is still honoured.
- bit_count never exceeds NUM_BITS-1 at any observable edge.

## Timing
- All outputs registered; no combinational input-to-output paths.
- Latency from the last shift_enable edge to parallel_out/data_valid/frame_done: 1 clock (visible in the cycle after the sampling edge).
- Back-to-back shift_enable every cycle is supported; the next frame starts counting on the cycle after completion with no dead cycle.
- rst asserted mid-frame: all state returns immediately (asynchronously) to reset values, and any partial or unread frame is lost.

## Test plan
- Reset: assert rst mid-stream with NUM_BITS=8, FILL_BIT=1 -> shift_out=parallel_out=0xFF, bit_count=0, data_valid=frame_done=overrun=0 without waiting for a clock.
- MSB-first frame: SHIFT_MSB=1, shift 1,0,1,0,0,1,0,1 on consecutive cycles -> bit_count steps 1..7 then 0; parallel_out=0xA5, data_valid=1, frame_done high exactly one cycle; data_read -> data_valid=0.
- LSB-first frame: SHIFT_MSB=0, shift 0xA5 LSB first (1,0,1,0,0,1,0,1) -> parallel_out=0xA5.
- Overrun: complete 0x3C, no read, complete 0xC3 -> parallel_out=0xC3, overrun=1, data_valid=1; data_read -> overrun=0, data_valid=0. Repeat with data_read on the completing cycle -> overrun stays 0, data_valid stays 1.
- Clear mid-frame: shift 5 bits, assert clear together with shift_enable -> bit_count=0, shift_out=0xFF, no frame_done; holding register and data_valid unchanged. Then 8 fresh bits -> a correct frame.
- Gapped stream: shift_enable toggles randomly over 1000 bits against a reference model -> every completed word, frame_done pulse, data_valid and overrun value matches.

Source files
------------

// File: rtl/flex_sipo_framer.sv
// Serial-to-parallel framer. Collects NUM_BITS serial bits and latches each completed word into a holding register.
// The holding register has a valid/read handshake and sticky overrun detection.
module flex_sipo_framer #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1,
    parameter bit FILL_BIT  = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              shift_enable,
    input  logic                              serial_in,
    input  logic                              clear,
    input  logic                              data_read,
    output logic [NUM_BITS-1:0]               shift_out,
    output logic [NUM_BITS-1:0]               parallel_out,
    output logic [$clog2(NUM_BITS+1)-1:0]     bit_count,
    output logic                              data_valid,
    output logic                              frame_done,
    output logic                              overrun
);

    localparam int CW = $clog2(NUM_BITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BITS - 1);

    logic [NUM_BITS-1:0] shift_reg, shift_next, shifted;
    logic [NUM_BITS-1:0] par_reg, par_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic                valid_reg, valid_next;
    logic                done_reg, done_next;
    logic                ovr_reg, ovr_next;

    // The direction decides which end the new bit enters and which neighbour feeds each bit.
    for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_shift
        if (SHIFT_MSB) begin : g_msb
            if (gi == 0) begin : g_in
                assign shifted[gi] = serial_in;
            end else begin : g_mv
                assign shifted[gi] = shift_reg[gi-1];
            end
        end else begin : g_lsb
            if (gi == NUM_BITS - 1) begin : g_in
                assign shifted[gi] = serial_in;
            end else begin : g_mv
                assign shifted[gi] = shift_reg[gi+1];
            end
        end
    end

    always_comb begin
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        par_next   = par_reg;
        valid_next = valid_reg;
        ovr_next   = ovr_reg;
        done_next  = 1'b0;

        // A bit arriving together with clear is dropped, so it can never complete a frame.
        if (clear) begin
            shift_next = {NUM_BITS{FILL_BIT}};
            cnt_next   = '0;
        end else if (shift_enable) begin
            shift_next = shifted;
            if (cnt_reg == LAST_CNT) begin
                cnt_next  = '0;
                done_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end

        if (done_next) begin
            par_next   = shifted;
            valid_next = 1'b1;
            ovr_next   = data_read ? 1'b0 : (valid_reg | ovr_reg);
        end else if (data_read) begin
            valid_next = 1'b0;
            ovr_next   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= {NUM_BITS{FILL_BIT}};
            par_reg   <= {NUM_BITS{FILL_BIT}};
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            par_reg   <= par_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign shift_out    = shift_reg;
    assign parallel_out = par_reg;
    assign bit_count    = cnt_reg;
    assign data_valid   = valid_reg;
    assign frame_done   = done_reg;
    assign overrun      = ovr_reg;

endmodule

// File: tb/tb_flex_sipo_framer.sv
// Bench for flex_sipo_framer: an MSB-first and an LSB-first instance are driven by the same stimulus.
// Each completed word is queued on stimulus and popped when the matching frame_done appears.
module tb_flex_sipo_framer;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic clk, rst, shift_enable, serial_in, clear, data_read;
    logic [N-1:0]  so_m, po_m, so_l, po_l;
    logic [CW-1:0] bc_m, bc_l;
    logic dv_m, fd_m, ov_m, dv_l, fd_l, ov_l;

    flex_sipo_framer #(.NUM_BITS(N), .SHIFT_MSB(1'b1), .FILL_BIT(1'b1)) dut_m (
        .clk(clk), .rst(rst), .shift_enable(shift_enable), .serial_in(serial_in),
        .clear(clear), .data_read(data_read), .shift_out(so_m), .parallel_out(po_m),
        .bit_count(bc_m), .data_valid(dv_m), .frame_done(fd_m), .overrun(ov_m));

    flex_sipo_framer #(.NUM_BITS(N), .SHIFT_MSB(1'b0), .FILL_BIT(1'b1)) dut_l (
        .clk(clk), .rst(rst), .shift_enable(shift_enable), .serial_in(serial_in),
        .clear(clear), .data_read(data_read), .shift_out(so_l), .parallel_out(po_l),
        .bit_count(bc_l), .data_valid(dv_l), .frame_done(fd_l), .overrun(ov_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [N-1:0] m_sm, m_sl, m_pm, m_pl;
    int           m_cnt;
    logic         m_valid, m_done, m_ovr;
    logic [N-1:0] q_m[$];
    logic [N-1:0] q_l[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sm = '1; m_sl = '1; m_pm = '1; m_pl = '1;
        m_cnt = 0; m_valid = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
        q_m.delete();
        q_l.delete();
    endtask

    task automatic model_edge();
        logic done;
        done = shift_enable && !clear && (m_cnt == N - 1);
        if (clear) begin
            m_sm = '1; m_sl = '1; m_cnt = 0;
        end else if (shift_enable) begin
            m_sm = {m_sm[N-2:0], serial_in};
            m_sl = {serial_in, m_sl[N-1:1]};
            m_cnt = done ? 0 : m_cnt + 1;
        end
        m_done = done;
        if (done) begin
            m_pm = m_sm;
            m_pl = m_sl;
            q_m.push_back(m_sm);
            q_l.push_back(m_sl);
            m_ovr = data_read ? 1'b0 : (m_valid ? 1'b1 : m_ovr);
            m_valid = 1'b1;
        end else if (data_read) begin
            m_valid = 1'b0;
            m_ovr = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("bit_count_m", 32'(bc_m), 32'(m_cnt));
        chk("bit_count_l", 32'(bc_l), 32'(m_cnt));
        chk("shift_out_m", 32'(so_m), 32'(m_sm));
        chk("shift_out_l", 32'(so_l), 32'(m_sl));
        chk("parallel_out_m", 32'(po_m), 32'(m_pm));
        chk("parallel_out_l", 32'(po_l), 32'(m_pl));
        chk("data_valid", 32'({dv_m, dv_l}), 32'({m_valid, m_valid}));
        chk("frame_done", 32'({fd_m, fd_l}), 32'({m_done, m_done}));
        chk("overrun", 32'({ov_m, ov_l}), 32'({m_ovr, m_ovr}));
        if (fd_m) begin
            if (q_m.size() == 0) chk("sb_m_empty", 32'(1), 32'(0));
            else chk("sb_word_m", 32'(po_m), 32'(q_m.pop_front()));
        end
        if (fd_l) begin
            if (q_l.size() == 0) chk("sb_l_empty", 32'(1), 32'(0));
            else chk("sb_word_l", 32'(po_l), 32'(q_l.pop_front()));
        end
    endtask

    task automatic step(input logic se, input logic si, input logic clr, input logic rd);
        shift_enable = se; serial_in = si; clear = clr; data_read = rd;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Shift one byte MSB-first in stream order; rd_last asserts data_read on the completing bit.
    task automatic send_byte(input logic [7:0] b, input logic rd_last);
        for (int i = 7; i >= 0; i--) step(1'b1, b[i], 1'b0, (i == 0) ? rd_last : 1'b0);
    endtask

    initial begin
        rst = 1'b1; shift_enable = 0; serial_in = 0; clear = 0; data_read = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // MSB/LSB frame of 0xA5 (bit pattern is its own reverse)
        send_byte(8'hA5, 1'b0);
        chk("a5_par_m", 32'(po_m), 32'h A5);
        chk("a5_par_l", 32'(po_l), 32'h A5);
        chk("a5_done", 32'(fd_m), 32'(1));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("a5_done_drop", 32'(fd_m), 32'(0));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("a5_read_valid", 32'(dv_m), 32'(0));

        // Overrun, then cleared by read
        send_byte(8'h3C, 1'b0);
        send_byte(8'hC3, 1'b0);
        chk("ovr_par", 32'(po_m), 32'h C3);
        chk("ovr_set", 32'({ov_m, dv_m}), 32'b11);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_read", 32'({ov_m, dv_m}), 32'b00);

        // Completion coinciding with read
        send_byte(8'h3C, 1'b0);
        send_byte(8'hC3, 1'b1);
        chk("ovr_rd_same", 32'({ov_m, dv_m}), 32'b01);

        // Clear mid-frame with shift_enable high; holding register stays valid
        for (int i = 0; i < 5; i++) step(1'b1, 1'(i & 1), 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_cnt", 32'(bc_m), 32'(0));
        chk("clr_shift", 32'(so_m), 32'h FF);
        chk("clr_keep", 32'({fd_m, dv_m}), 32'b01);
        chk("clr_keep_par", 32'(po_m), 32'h C3);
        send_byte(8'h5A, 1'b1);
        chk("clr_fresh_m", 32'(po_m), 32'h 5A);
        chk("clr_fresh_l", 32'(po_l), 32'h 5A);

        // Asynchronous reset mid-stream, checked without a clock edge
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;

        // Gapped random stream
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) == 0));
        end
        chk("sb_drained", 32'(q_m.size() + q_l.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
